fc3_argmax: RTL and testbench

Sequential argmax stage directly downstream of the fc3 fully-connected layer (84 inputs, 10 neurons, ReLU outputs). It captures the ten post-ReLU class scores in one valid/ready handshake, scans them one per clock, and presents the winning class index and its score through a valid/ready output handshake. This block is the final classification stage of the network datapath.

---
 rtl/fc3_argmax.sv | 103 ++++++++++
 tb/tb_fc3_argmax.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fc3_argmax.sv
// Sequential argmax over the fc3 class scores: one vector per handshake, one score per clock.
// Optional tie flag output is enabled by defining FC3_ARGMAX_TIE_FLAG_EN.
module fc3_argmax #(
  parameter int WIDTH   = 8,
  parameter int Z_WIDTH = WIDTH*2+6,
  parameter int N_CLASS = 10,
  localparam int IDX_W  = $clog2(N_CLASS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [Z_WIDTH-1:0] z [N_CLASS],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   class_idx,
  output logic [Z_WIDTH-1:0] max_score
`ifdef FC3_ARGMAX_TIE_FLAG_EN
  ,output logic              tie
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [Z_WIDTH-1:0] score_buf [N_CLASS];
  logic [Z_WIDTH-1:0] best_val;
  logic [IDX_W-1:0]   best_idx;
  logic [IDX_W-1:0]   ptr;
  logic               accept;
  logic               last;
  logic               greater;
`ifdef FC3_ARGMAX_TIE_FLAG_EN
  logic               tie_q;
`endif

  assign accept  = in_valid && (state_q == IDLE);
  assign last    = (ptr == IDX_W'(N_CLASS-1));
  assign greater = score_buf[ptr] > best_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = SCAN;
      SCAN:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: the score bank has no reset; it is always rewritten at accept before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N_CLASS; i++) score_buf[i] <= z[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else if (accept) begin
      ptr      <= IDX_W'(1);
      best_val <= z[0];
      best_idx <= '0;
    end else if (state_q == SCAN) begin
      // Strict compare keeps the lowest index on ties.
      if (greater) begin
        best_val <= score_buf[ptr];
        best_idx <= ptr;
      end
      ptr <= ptr + IDX_W'(1);
    end
  end

`ifdef FC3_ARGMAX_TIE_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tie_q <= 1'b0;
    end else if (accept) begin
      tie_q <= 1'b0;
    end else if (state_q == SCAN) begin
      if (greater)                            tie_q <= 1'b0;
      else if (score_buf[ptr] == best_val)    tie_q <= 1'b1;
    end
  end

  assign tie = tie_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign class_idx = best_idx;
  assign max_score = best_val;

endmodule

// File: tb/tb_fc3_argmax.sv
// Directed self-checking bench for fc3_argmax at default parameters.
// Tie-flag checks are included when FC3_ARGMAX_TIE_FLAG_EN is defined.
module tb_fc3_argmax;

  localparam int ZW = 22;
  localparam int NC = 10;

  typedef logic [ZW-1:0] vec_t [NC];

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  vec_t          z;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    class_idx;
  logic [ZW-1:0] max_score;
`ifdef FC3_ARGMAX_TIE_FLAG_EN
  logic          tie;
`endif

  int checks   = 0;
  int failures = 0;

  vec_t v_single, v_tie, v_zero, v_ext, v_desc, v_junk;

  always #5 clk = ~clk;

  fc3_argmax dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .class_idx (class_idx),
    .max_score (max_score)
`ifdef FC3_ARGMAX_TIE_FLAG_EN
    ,.tie      (tie)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Presents v for one handshake; returns at the negedge after the accept edge.
  task automatic accept_vec(input vec_t v, input string tag);
    @(negedge clk);
    z        = v;
    in_valid = 1'b1;
    #1 check({tag, "_in_ready_idle"}, 32'(in_ready), 1);
    @(posedge clk);
    #1 check({tag, "_in_ready_scan"}, 32'(in_ready), 0);
    @(negedge clk);
    in_valid = 1'b0;
    z        = v_junk;
  endtask

  // Counts rising edges after the accept edge until out_valid, bounded.
  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      cyc = i;
      if (out_valid) break;
    end
    check({tag, "_latency"}, 32'(out_valid ? cyc : 99), 9);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_hs_out_valid"}, 32'(out_valid), 0);
    check({tag, "_hs_in_ready"}, 32'(in_ready), 1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int e_idx, input int e_val,
                         input int e_tie, input string tag);
    accept_vec(v, tag);
    wait_done(tag);
    check({tag, "_class_idx"}, 32'(class_idx), 32'(e_idx));
    check({tag, "_max_score"}, 32'(max_score), 32'(e_val));
`ifdef FC3_ARGMAX_TIE_FLAG_EN
    check({tag, "_tie"}, 32'(tie), 32'(e_tie));
`else
    if (e_tie > 1) $display("note: unexpected tie expectation %0d", e_tie);
`endif
    handshake(tag);
  endtask

  initial begin
    v_single = '{0, 5, 3, 100, 7, 0, 0, 0, 0, 2};
    v_tie    = '{0, 0, 50, 0, 0, 0, 0, 50, 0, 0};
    v_zero   = '{default: '0};
    v_ext    = '{default: 22'h3FFFFE};
    v_ext[9] = 22'h3FFFFF;
    v_desc   = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    v_junk   = '{default: 22'h3FFFFF};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    z         = v_zero;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_class_idx", 32'(class_idx), 0);
    check("rst_max_score", 32'(max_score), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_in_ready", 32'(in_ready), 1);

    run_vec(v_single, 3, 100, 0, "single");
    run_vec(v_tie, 2, 50, 1, "tie");
    run_vec(v_zero, 0, 0, 1, "zero");
    run_vec(v_ext, 9, 32'h3FFFFF, 0, "extreme");

    // Backpressure: result must hold and new vectors must wait.
    accept_vec(v_single, "bp");
    wait_done("bp");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      z        = v_desc;
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_idx", 32'(class_idx), 3);
      check("bp_hold_score", 32'(max_score), 100);
      check("bp_hold_in_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_hs_out_valid", 32'(out_valid), 0);
    check("bp_hs_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1 check("bp_next_accepted", 32'(in_ready), 0);
    @(negedge clk);
    in_valid = 1'b0;
    z        = v_junk;
    wait_done("bp_next");
    check("bp_next_idx", 32'(class_idx), 0);
    check("bp_next_score", 32'(max_score), 9);
    handshake("bp_next");

    // Reset while ptr == 4: best so far is index 3 / 100.
    accept_vec(v_single, "mid");
    repeat (3) @(posedge clk);
    #1;
    check("mid_pre_idx", 32'(class_idx), 3);
    check("mid_pre_score", 32'(max_score), 100);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_class_idx", 32'(class_idx), 0);
    check("mid_rst_max_score", 32'(max_score), 0);
`ifdef FC3_ARGMAX_TIE_FLAG_EN
    check("mid_rst_tie", 32'(tie), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run_vec(v_desc, 0, 9, 0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
